// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the pipeline stall/flush controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  localparam int DRAIN_CYCLES_DEF = 3;

  typedef logic [3:0] reg_idx_t;

  function automatic logic src_match(input logic used, input reg_idx_t src, input reg_idx_t rd);
    return used && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard between the EX load and the ID sources
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       memory_en_ex_i,
  input  logic       memory_we_ex_i,
  input  logic       register_we_ex_i,
  input  logic [3:0] rd_ex_i,
  input  logic [3:0] rs_id_i,
  input  logic [3:0] rt_id_i,
  input  logic       rs_used_id_i,
  input  logic       rt_used_id_i,
  output logic       load_use_o
);

  logic is_load;

  // R0 is hardwired, so a load targeting it never creates a dependency
  assign is_load    = memory_en_ex_i & ~memory_we_ex_i & register_we_ex_i & (rd_ex_i != 4'd0);
  assign load_use_o = is_load & (src_match(rs_used_id_i, rs_id_i, rd_ex_i) |
                                 src_match(rt_used_id_i, rt_id_i, rd_ex_i));

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - stall/flush sequencer for the five-stage pipeline
// Mealy enables/flushes from state and hazards; registered drain counter and stall counter.
module pipeline_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             branch_taken_ID,
  input  logic             halt_ID,
  input  logic             memory_en_EX,
  input  logic             memory_we_EX,
  input  logic             register_we_EX,
  input  logic [3:0]       rd_EX,
  input  logic [3:0]       rs_ID,
  input  logic [3:0]       rt_ID,
  input  logic             rs_used_ID,
  input  logic             rt_used_ID,
  output logic             pc_we,
  output logic             IF_ID_we,
  output logic             ID_EX_we,
  output logic             EX_MEM_we,
  output logic             MEM_WB_we,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             MEM_WB_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  ctrl_state_t      state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             load_use;
  logic             front_stall;

  hazard_detect u_hazard_detect (
    .memory_en_ex_i   (memory_en_EX),
    .memory_we_ex_i   (memory_we_EX),
    .register_we_ex_i (register_we_EX),
    .rd_ex_i          (rd_EX),
    .rs_id_i          (rs_ID),
    .rt_id_i          (rt_ID),
    .rs_used_id_i     (rs_used_ID),
    .rt_used_id_i     (rt_used_ID),
    .load_use_o       (load_use)
  );

  assign front_stall = load_use | icache_stall;
  assign stall_count = stall_count_q;

  always_comb begin
    pc_we        = 1'b1;
    IF_ID_we     = 1'b1;
    ID_EX_we     = 1'b1;
    EX_MEM_we    = 1'b1;
    MEM_WB_we    = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    MEM_WB_flush = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      {pc_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we} = 5'b00000;
      {IF_ID_flush, ID_EX_flush, MEM_WB_flush}          = 3'b111;
    end else begin
      case (state_q)
        RUN: begin
          if (dcache_stall) begin
            {pc_we, IF_ID_we, ID_EX_we, EX_MEM_we} = 4'b0000;
            MEM_WB_flush = 1'b1;
          end else if (front_stall) begin
            pc_we       = 1'b0;
            IF_ID_we    = 1'b0;
            ID_EX_flush = 1'b1;
          end else if (branch_taken_ID) begin
            IF_ID_flush = 1'b1;
          end else if (halt_ID) begin
            pc_we       = 1'b0;
            IF_ID_flush = 1'b1;
          end
        end
        DRAIN: begin
          pc_we       = 1'b0;
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
          if (dcache_stall) begin
            {IF_ID_we, ID_EX_we, EX_MEM_we} = 3'b000;
            MEM_WB_flush = 1'b1;
          end
        end
        default: begin
          {pc_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we} = 5'b00000;
          halted = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_count_d = stall_count_q;
    case (state_q)
      RUN: begin
        if (!dcache_stall && !front_stall && !branch_taken_ID && halt_ID) begin
          state_d = DRAIN;
          cnt_d   = 2'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        // a D-cache miss holds the halt in place, so the countdown freezes with it
        if (!dcache_stall) begin
          if (cnt_q == 2'd0) state_d = HALTED;
          else               cnt_d   = cnt_q - 2'd1;
        end
      end
      default: ;
    endcase
    if (state_q != HALTED && (dcache_stall | front_stall) && stall_count_q != '1)
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= 2'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed self-checking bench for pipeline_controller
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_stall = 1'b0, dcache_stall = 1'b0;
  logic        branch_taken_ID = 1'b0, halt_ID = 1'b0;
  logic        memory_en_EX = 1'b0, memory_we_EX = 1'b0, register_we_EX = 1'b0;
  logic [3:0]  rd_EX = 4'd0, rs_ID = 4'd0, rt_ID = 4'd0;
  logic        rs_used_ID = 1'b0, rt_used_ID = 1'b0;
  logic        pc_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we;
  logic        IF_ID_flush, ID_EX_flush, MEM_WB_flush, halted;
  logic [15:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  // {pc, IF_ID, ID_EX, EX_MEM, MEM_WB we | IF_ID, ID_EX, MEM_WB flush | halted}
  logic [8:0] outs;
  assign outs = {pc_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we,
                 IF_ID_flush, ID_EX_flush, MEM_WB_flush, halted};

  localparam logic [8:0] V_RESET  = 9'b00000_111_0;
  localparam logic [8:0] V_IDLE   = 9'b11111_000_0;
  localparam logic [8:0] V_FRONT  = 9'b00111_010_0;
  localparam logic [8:0] V_DCACHE = 9'b00001_001_0;
  localparam logic [8:0] V_BRANCH = 9'b11111_100_0;
  localparam logic [8:0] V_HALTID = 9'b01111_100_0;
  localparam logic [8:0] V_DRAIN  = 9'b01111_110_0;
  localparam logic [8:0] V_DRDC   = 9'b00001_111_0;
  localparam logic [8:0] V_HALTED = 9'b00000_000_1;

  pipeline_controller #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .branch_taken_ID(branch_taken_ID), .halt_ID(halt_ID),
    .memory_en_EX(memory_en_EX), .memory_we_EX(memory_we_EX), .register_we_EX(register_we_EX),
    .rd_EX(rd_EX), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .rs_used_ID(rs_used_ID), .rt_used_ID(rt_used_ID),
    .pc_we(pc_we), .IF_ID_we(IF_ID_we), .ID_EX_we(ID_EX_we),
    .EX_MEM_we(EX_MEM_we), .MEM_WB_we(MEM_WB_we),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .MEM_WB_flush(MEM_WB_flush),
    .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [3:0] rd, input logic [3:0] rs, input logic rs_used);
    memory_en_EX   = 1'b1;
    memory_we_EX   = 1'b0;
    register_we_EX = 1'b1;
    rd_EX          = rd;
    rs_ID          = rs;
    rs_used_ID     = rs_used;
  endtask

  task automatic clear_ex();
    memory_en_EX   = 1'b0;
    register_we_EX = 1'b0;
    rd_EX          = 4'd0;
    rs_used_ID     = 1'b0;
    rt_used_ID     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_outs", 32'(outs), 32'(V_RESET));
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #2;
    check("por_outs", 32'(outs), 32'(V_RESET));
    check("por_count", 32'(stall_count), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("idle_outs", 32'(outs), 32'(V_IDLE));

    // load-use on rs: one bubble
    set_load(4'd3, 4'd3, 1'b1);
    #1;
    check("lu_rs_outs", 32'(outs), 32'(V_FRONT));
    tick();
    clear_ex();
    #1;
    check("lu_after_outs", 32'(outs), 32'(V_IDLE));
    check("lu_count", 32'(stall_count), 32'd1);

    // same load to R0: no hazard
    set_load(4'd0, 4'd0, 1'b1);
    #1;
    check("lu_r0_outs", 32'(outs), 32'(V_IDLE));
    tick();
    check("lu_r0_count", 32'(stall_count), 32'd1);

    // rt match only counts when rt is actually read
    set_load(4'd5, 4'd1, 1'b1);
    rt_ID = 4'd5;
    rt_used_ID = 1'b0;
    #1;
    check("lu_rt_unused", 32'(outs), 32'(V_IDLE));
    rt_used_ID = 1'b1;
    #1;
    check("lu_rt_used", 32'(outs), 32'(V_FRONT));
    memory_we_EX = 1'b1;
    #1;
    check("store_no_lu", 32'(outs), 32'(V_IDLE));
    clear_ex();
    memory_we_EX = 1'b0;

    // 4-cycle D-cache miss
    dcache_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("dc_outs_%0d", i), 32'(outs), 32'(V_DCACHE));
      tick();
    end
    dcache_stall = 1'b0;
    #1;
    check("dc_release", 32'(outs), 32'(V_IDLE));
    check("dc_count", 32'(stall_count), 32'd5);

    // I-cache miss holds a taken branch
    icache_stall    = 1'b1;
    branch_taken_ID = 1'b1;
    #1;
    check("ic_br_outs", 32'(outs), 32'(V_FRONT));
    tick();
    icache_stall = 1'b0;
    #1;
    check("br_outs", 32'(outs), 32'(V_BRANCH));
    tick();
    branch_taken_ID = 1'b0;
    #1;
    check("br_count", 32'(stall_count), 32'd6);

    // halt with no stalls: halted at T+3
    halt_ID = 1'b1;
    #1;
    check("halt_id_outs", 32'(outs), 32'(V_HALTID));
    tick();
    halt_ID = 1'b0;
    #1;
    check("drain1_outs", 32'(outs), 32'(V_DRAIN));
    icache_stall = 1'b1;
    branch_taken_ID = 1'b1;
    tick();
    icache_stall = 1'b0;
    branch_taken_ID = 1'b0;
    #1;
    check("drain2_outs", 32'(outs), 32'(V_DRAIN));
    tick();
    check("drain3_outs", 32'(outs), 32'(V_DRAIN));
    tick();
    check("halted_t3", 32'(outs), 32'(V_HALTED));
    check("drain_ic_count", 32'(stall_count), 32'd7);
    dcache_stall = 1'b1;
    tick();
    dcache_stall = 1'b0;
    check("halted_frozen", 32'(stall_count), 32'd7);
    check("halted_hold", 32'(outs), 32'(V_HALTED));

    // halt with a 2-cycle D-cache miss in DRAIN: halted at T+5
    do_reset();
    check("rst_halted_count", 32'(stall_count), 32'd0);
    check("rst_halted_outs", 32'(outs), 32'(V_IDLE));
    halt_ID = 1'b1;
    tick();
    halt_ID = 1'b0;
    tick();
    dcache_stall = 1'b1;
    #1;
    check("drain_dc_outs", 32'(outs), 32'(V_DRDC));
    tick();
    tick();
    dcache_stall = 1'b0;
    #1;
    check("drain_dc_after", 32'(outs), 32'(V_DRAIN));
    tick();
    check("drain_dc_t4", 32'(outs), 32'(V_DRAIN));
    tick();
    check("halted_t5", 32'(outs), 32'(V_HALTED));
    check("drain_dc_count", 32'(stall_count), 32'd2);

    // asynchronous reset mid-DRAIN
    do_reset();
    dcache_stall = 1'b1;
    tick();
    dcache_stall = 1'b0;
    halt_ID = 1'b1;
    tick();
    halt_ID = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outs", 32'(outs), 32'(V_RESET));
    check("async_rst_count", 32'(stall_count), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_outs", 32'(outs), 32'(V_IDLE));
    tick();
    tick();
    tick();
    check("post_rst_run", 32'(outs), 32'(V_IDLE));

    // saturation of the stall counter
    dcache_stall = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_minus1", 32'(stall_count), 32'h0000_FFFE);
    repeat (70000 - 65534) @(posedge clk);
    #1;
    check("sat_count", 32'(stall_count), 32'h0000_FFFF);
    dcache_stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the five-stage WISC pipeline. Drives write-enable (hold) and flush (synchronous clear through each pipeline register's `rst` pin) for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Resolves load-use hazards, I-/D-cache miss stalls, taken-branch redirects and halt drain. Keeps a saturating stall-cycle counter.

## Interface
Parameters:
- DRAIN_CYCLES, 3: non-stalled cycles from halt leaving ID until the halt completes WB.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- icache_stall  in  1  I-cache miss in progress.
- dcache_stall  in  1  D-cache miss in progress.
- branch_taken_ID  in  1  branch in ID resolved taken; PC mux selects target.
- halt_ID  in  1  HLT decoded in ID.
- memory_en_EX, memory_we_EX, register_we_EX  in  1 each  control bits of the instruction in EX.
- rd_EX  in  4  destination of the EX instruction.
- rs_ID, rt_ID  in  4 each  sources of the ID instruction.
- rs_used_ID, rt_used_ID  in  1 each  source actually read.
- pc_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we  out  1 each  register write enables.
- IF_ID_flush, ID_EX_flush, MEM_WB_flush  out  1 each  insert bubble (clear) next edge.
- halted  out  1  processor halted.
- stall_count  out  CNT_W  saturating stall-cycle count.

## Operation
- State: RUN, DRAIN, HALTED. Drain counter is 2 bits. stall_count is registered.
- Outputs are combinational from the state and current inputs (Mealy). The counter and stall_count are registered.
- load_use: memory_en_EX & ~memory_we_EX & register_we_EX & rd_EX≠0 & ((rs_used_ID & rs_ID==rd_EX) | (rt_used_ID & rt_ID==rd_EX)).
- Default (RUN, no event): all we=1, all flush=0.
- Priority, highest first:
  1. dcache_stall: pc/IF_ID/ID_EX/EX_MEM we=0; MEM_WB_flush=1.
  2. load_use or icache_stall: pc_we=0, IF_ID_we=0; ID_EX_flush=1; EX_MEM and MEM_WB advance.
  3. branch_taken_ID: pc_we=1 loads target; IF_ID_flush=1; rest advance.
  4. halt_ID in RUN: pc_we=0, IF_ID_flush=1; ID_EX captures the halt; go to DRAIN with cnt=DRAIN_CYCLES-1.
- A branch or halt in ID is not acted on while a rank-1/2 condition holds; it waits in IF/ID.
- DRAIN:
  - Every cycle: pc_we=0, IF_ID_flush=1, ID_EX_flush=1.
  - dcache_stall overrides exactly as in rank 1 and freezes cnt.
  - Otherwise cnt decrements. Go to HALTED on the cycle cnt==0 and no dcache_stall.
  - load_use, icache_stall and branch_taken_ID are ignored.
- HALTED: all we=0, all flush=0, halted=1. The only exit is rst.
- stall_count increments each cycle in RUN/DRAIN when dcache_stall, icache_stall or load_use is high. It holds at 2^CNT_W−1 and is frozen in HALTED.

## Timing
- Reset (async): state=RUN, cnt=0, stall_count=0. While rst=1: all we=0, all flush=1, halted=0.
- Load-use costs exactly one bubble: the next cycle EX holds the bubble, so load_use deasserts.
- Cache stalls persist for as many cycles as the stall input is high. Release is on the first edge after deassertion.
- Halt: halt_ID accepted at edge T. halted=1 from edge T+DRAIN_CYCLES, plus any dcache-stall cycles during DRAIN.
- rst mid-DRAIN or in HALTED: immediate return to RUN, counters cleared.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum {RUN, DRAIN, HALTED};
  - the DRAIN_CYCLES default;
  - the 4-bit register-index type.
- Sub-module hazard_detect: purely combinational load_use equation. The controller instantiates it once.

## Test plan
- LW R3 in EX, ADD in ID reading rs=3: one cycle with pc_we=0, IF_ID_we=0, ID_EX_flush=1; stall_count 0→1. Same with rd_EX=0: no stall.
- dcache_stall high 4 cycles: pc/IF_ID/ID_EX/EX_MEM we=0 and MEM_WB_flush=1 for 4 cycles; stall_count +=4.
- icache_stall coincident with branch_taken_ID: branch held (pc_we=0). After icache_stall drops: pc_we=1, IF_ID_flush=1 for one cycle.
- halt_ID at edge T, no stalls: halted rises at T+3. With a 2-cycle dcache_stall during DRAIN: halted rises at T+5; pc_we stays 0 throughout.
- 70000 stall cycles: stall_count saturates at 0xFFFF.
- rst asserted mid-DRAIN, asynchronously between edges: outputs immediately take reset values. After release: RUN, halted=0, stall_count=0.
